// File: rtl/des_core_arbiter.sv
// des_core_arbiter: round-robin sharing of one iterative DES core between two requesters,
// with a watchdog that turns a missing core_done into an error response.
module des_core_arbiter #(
  parameter int DATA_W  = 64,
  parameter int TIMEOUT = 31
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req_valid,
  output logic [1:0]        req_ready,
  input  logic [DATA_W-1:0] req0_data,
  input  logic [DATA_W-1:0] req1_data,
  input  logic [DATA_W-1:0] req0_key,
  input  logic [DATA_W-1:0] req1_key,
  input  logic              req0_decrypt,
  input  logic              req1_decrypt,
  output logic [1:0]        rsp_valid,
  input  logic [1:0]        rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic              core_start,
  output logic [DATA_W-1:0] core_data,
  output logic [DATA_W-1:0] core_key,
  output logic              core_decrypt,
  input  logic              core_done,
  input  logic [DATA_W-1:0] core_out
);
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);
  localparam logic [CW-1:0] CNT_MAX  = CW'(TIMEOUT);
  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
  state_t            state_q, state_d;
  logic              grant_q, grant_d, last_q, last_d, dec_q, dec_d, err_q, err_d;
  logic              live_q, live_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [DATA_W-1:0] data_q, data_d, key_q, key_d, out_q, out_d;
  logic              g, take;
  always_comb begin
    g            = (&req_valid) ? ~last_q : req_valid[1];
    // live_q keeps req_ready low while reset is (or was just) asserted
    take         = state_q == IDLE && live_q && |req_valid;
    req_ready    = take ? (g ? 2'b10 : 2'b01) : 2'b00;
    rsp_valid    = state_q == RESP ? (grant_q ? 2'b10 : 2'b01) : 2'b00;
    core_start   = state_q == ISSUE;
    core_data    = data_q;
    core_key     = key_q;
    core_decrypt = dec_q;
    rsp_data     = out_q;
    rsp_err      = err_q;
    live_d       = 1'b1;
    state_d      = state_q;
    grant_d      = grant_q;
    last_d       = last_q;
    cnt_d        = cnt_q;
    data_d       = data_q;
    key_d        = key_q;
    dec_d        = dec_q;
    out_d        = out_q;
    err_d        = err_q;
    case (state_q)
      IDLE: if (take) begin
        state_d = ISSUE;
        grant_d = g;
        data_d  = g ? req1_data : req0_data;
        key_d   = g ? req1_key : req0_key;
        dec_d   = g ? req1_decrypt : req0_decrypt;
      end
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT;
      end
      WAIT: if (core_done) begin
        out_d   = core_out;
        err_d   = 1'b0;
        state_d = RESP;
      end else if (cnt_q == CNT_LAST) begin
        out_d   = '0;
        err_d   = 1'b1;
        state_d = RESP;
      end else begin
        cnt_d = cnt_q == CNT_MAX ? cnt_q : cnt_q + 1'b1;
      end
      RESP: if (rsp_ready[grant_q]) begin
        last_d  = grant_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= 1'b0;
      last_q  <= 1'b1;
      live_q  <= 1'b0;
      cnt_q   <= '0;
      data_q  <= '0;
      key_q   <= '0;
      dec_q   <= 1'b0;
      out_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      last_q  <= last_d;
      live_q  <= live_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      key_q   <= key_d;
      dec_q   <= dec_d;
      out_q   <= out_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: tb/tb_des_core_arbiter.sv
// tb_des_core_arbiter: directed vector table plus randomized transactions checked
// against a transaction-level round-robin/watchdog model; a TIMEOUT=3 copy covers the done/timeout tie.
module tb_des_core_arbiter;
  localparam int TO = 5;
  typedef struct {
    logic [1:0]  rv;
    int          delay;
    int          stall;
    logic [63:0] data;
    logic [63:0] key;
    logic        dec;
    logic [63:0] val;
    logic        g;
    logic        err;
  } vec_t;
  logic        clk = 0, rst = 0;
  logic [1:0]  req_valid = '0, rsp_ready = '0;
  logic [63:0] d0 = '0, d1 = '0, k0 = '0, k1 = '0, core_out = '0;
  logic        dec0 = 0, dec1 = 0, core_done = 0;
  logic [1:0]  req_ready, rsp_valid, req_ready3, rsp_valid3;
  logic [63:0] rsp_data, core_data, core_key, rsp_data3, core_data3, core_key3;
  logic        rsp_err, core_start, core_decrypt, rsp_err3, core_start3, core_decrypt3;
  int          tests = 0, fails = 0;
  int          core_delay = 0, pend = 0;
  logic [63:0] core_val = '0;
  logic        spur = 0;
  logic        last = 1;
  vec_t        vecs[12];

  always #5 clk = ~clk;

  des_core_arbiter #(.DATA_W(64), .TIMEOUT(TO)) u_dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req0_data(d0), .req1_data(d1), .req0_key(k0), .req1_key(k1),
    .req0_decrypt(dec0), .req1_decrypt(dec1), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .core_start(core_start), .core_data(core_data),
    .core_key(core_key), .core_decrypt(core_decrypt), .core_done(core_done), .core_out(core_out));

  des_core_arbiter #(.DATA_W(64), .TIMEOUT(3)) u_dut3 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready3),
    .req0_data(d0), .req1_data(d1), .req0_key(k0), .req1_key(k1),
    .req0_decrypt(dec0), .req1_decrypt(dec1), .rsp_valid(rsp_valid3), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data3), .rsp_err(rsp_err3), .core_start(core_start3), .core_data(core_data3),
    .core_key(core_key3), .core_decrypt(core_decrypt3), .core_done(core_done), .core_out(core_out));

  // Core model: done pulses on the core_delay-th WAIT cycle after a start (0 = never).
  initial forever begin
    @(posedge clk);
    #1;
    core_done = 0;
    if (!rst) pend = 0;
    else if (core_start) pend = core_delay;
    else if (pend > 0) begin
      pend--;
      if (pend == 0) begin
        core_done = 1;
        core_out  = core_val;
      end
    end
    if (spur) begin
      core_done = 1;
      core_out  = '1;
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_req_ready"}, req_ready, 0);
    chk({tag, "_rsp_valid"}, rsp_valid, 0);
    chk({tag, "_rsp_data"}, rsp_data, 0);
    chk({tag, "_rsp_err"}, rsp_err, 0);
    chk({tag, "_core_start"}, core_start, 0);
    chk({tag, "_core_data"}, core_data, 0);
    chk({tag, "_core_key"}, core_key, 0);
    chk({tag, "_core_decrypt"}, core_decrypt, 0);
  endtask

  task automatic run_tx(input vec_t v, input bit chk3);
    logic [1:0]  oh      = v.g ? 2'b10 : 2'b01;
    int          lat     = v.err ? TO + 2 : v.delay + 2;
    logic [63:0] exp_out = v.err ? 64'd0 : v.val;
    req_valid  = v.rv;
    d0 = v.g ? ~v.data : v.data;
    d1 = v.g ? v.data : ~v.data;
    k0 = v.g ? ~v.key : v.key;
    k1 = v.g ? v.key : ~v.key;
    dec0 = v.g ? ~v.dec : v.dec;
    dec1 = v.g ? v.dec : ~v.dec;
    core_delay = v.delay;
    core_val   = v.val;
    rsp_ready  = '0;
    #1 chk("grant_req_ready", req_ready, oh);
    step();
    #1 chk("issue_core_start", core_start, 1);
    chk("issue_core_data", core_data, v.data);
    chk("issue_core_key", core_key, v.key);
    chk("issue_core_decrypt", core_decrypt, v.dec);
    chk("issue_req_ready", req_ready, 0);
    for (int i = 2; i < lat; i++) begin
      step();
      #1 chk("wait_rsp_valid", rsp_valid, 0);
      chk("wait_core_start", core_start, 0);
    end
    step();
    #1 chk("rsp_valid", rsp_valid, oh);
    chk("rsp_data", rsp_data, exp_out);
    chk("rsp_err", rsp_err, v.err);
    if (chk3) begin
      chk("t3_rsp_valid", rsp_valid3, oh);
      chk("t3_rsp_err", rsp_err3, 0);
      chk("t3_rsp_data", rsp_data3, v.val);
      chk("t3_core_data", core_data3, v.data);
      chk("t3_core_key", core_key3, v.key);
      chk("t3_core_decrypt", core_decrypt3, v.dec);
      chk("t3_core_start", core_start3, 0);
      chk("t3_req_ready", req_ready3, 0);
    end
    rsp_ready = ~oh;
    for (int i = 0; i < v.stall; i++) begin
      step();
      #1 chk("stall_rsp_valid", rsp_valid, oh);
      chk("stall_rsp_data", rsp_data, exp_out);
      chk("stall_rsp_err", rsp_err, v.err);
      chk("stall_req_ready", req_ready, 0);
    end
    rsp_ready = oh;
    step();
    #1 chk("handshake_rsp_valid", rsp_valid, 0);
    rsp_ready = '0;
    req_valid = '0;
    last = v.g;
  endtask

  task automatic reset_mid(input int idx);
    req_valid  = 2'b01;
    d0 = 64'hFEED_FACE_0000_1234;
    k0 = 64'h0F1E_2D3C_4B5A_6978;
    dec0 = 1;
    core_delay = 0;
    repeat (idx) step();
    #1 chk("pre_rst_core_start", core_start, idx == 1);
    #1 rst = 0;
    #1 chk_zero("async_rst");
    req_valid = '0;
    step();
    step();
    rst = 1;
    last = 1;
    step();
    #1 chk("post_rst_rsp_valid", rsp_valid, 0);
    step();
    #1 chk("post_rst_rsp_valid2", rsp_valid, 0);
  endtask

  initial begin
    vecs[0]  = '{2'b11, 1, 0, 64'h1111_0000_AAAA_0001, 64'h0101_0101_0101_0101, 1'b0, 64'hC0DE_0000_0000_0001, 1'b0, 1'b0};
    vecs[1]  = '{2'b11, 2, 0, 64'h2222_1111_BBBB_0002, 64'h0202_0202_0202_0202, 1'b1, 64'hC0DE_0000_0000_0002, 1'b1, 1'b0};
    vecs[2]  = '{2'b11, 3, 0, 64'h3333_2222_CCCC_0003, 64'h0303_0303_0303_0303, 1'b0, 64'hC0DE_0000_0000_0003, 1'b0, 1'b0};
    vecs[3]  = '{2'b11, 4, 0, 64'h4444_3333_DDDD_0004, 64'h0404_0404_0404_0404, 1'b1, 64'hC0DE_0000_0000_0004, 1'b1, 1'b0};
    vecs[4]  = '{2'b01, 2, 0, 64'h0123_4567_89AB_CDEF, 64'h1334_5779_9BBC_DFF1, 1'b0, 64'h85E8_1354_0F0A_B405, 1'b0, 1'b0};
    vecs[5]  = '{2'b10, 0, 0, 64'h5555_AAAA_5555_AAAA, 64'h0505_0505_0505_0505, 1'b0, 64'hDEAD_BEEF_0000_0005, 1'b1, 1'b1};
    vecs[6]  = '{2'b11, 1, 10, 64'h6666_0000_6666_0006, 64'h0606_0606_0606_0606, 1'b1, 64'hC0DE_0000_0000_0006, 1'b0, 1'b0};
    vecs[7]  = '{2'b11, 1, 0, 64'h7777_0000_7777_0007, 64'h0707_0707_0707_0707, 1'b0, 64'hC0DE_0000_0000_0007, 1'b1, 1'b0};
    vecs[8]  = '{2'b01, 6, 0, 64'h8888_0000_8888_0008, 64'h0808_0808_0808_0808, 1'b0, 64'hBAD0_0000_0000_0008, 1'b0, 1'b1};
    vecs[9]  = '{2'b10, 7, 0, 64'h9999_0000_9999_0009, 64'h0909_0909_0909_0909, 1'b1, 64'hBAD0_0000_0000_0009, 1'b1, 1'b1};
    vecs[10] = '{2'b11, 5, 2, 64'hAAAA_0000_AAAA_000A, 64'h0A0A_0A0A_0A0A_0A0A, 1'b0, 64'hC0DE_0000_0000_000A, 1'b0, 1'b0};
    vecs[11] = '{2'b01, 1, 1, 64'hBBBB_0000_BBBB_000B, 64'h0B0B_0B0B_0B0B_0B0B, 1'b1, 64'hC0DE_0000_0000_000B, 1'b0, 1'b0};
    req_valid = 2'b11;
    #3 chk_zero("reset");
    req_valid = '0;
    step();
    step();
    rst = 1;
    step();
    for (int i = 0; i < 12; i++) begin
      run_tx(vecs[i], 0);
      if (i == 5) begin
        spur = 1;
        step();
        spur = 0;
        step();
        #1 chk("spur_rsp_valid", rsp_valid, 0);
        chk("spur_core_start", core_start, 0);
        chk("spur_rsp_data", rsp_data, 0);
        chk("spur_rsp_err", rsp_err, 1);
      end
    end
    reset_mid(3);
    reset_mid(1);
    run_tx('{2'b11, 3, 0, 64'hC011_1DE0_C011_1DE0, 64'h1234_5678_9ABC_DEF0, 1'b1, 64'h600D_600D_600D_600D, 1'b0, 1'b0}, 1);
    for (int n = 0; n < 40; n++) begin
      vec_t v;
      v.rv    = 2'($urandom_range(1, 3));
      v.delay = $urandom_range(0, 8);
      v.stall = $urandom_range(0, 3);
      v.data  = {$urandom, $urandom};
      v.key   = {$urandom, $urandom};
      v.dec   = 1'($urandom_range(0, 1));
      v.val   = {$urandom, $urandom};
      v.g     = (v.rv == 2'b01) ? 1'b0 : (v.rv == 2'b10) ? 1'b1 : (last == 1'b0);
      v.err   = !(v.delay >= 1 && v.delay <= TO);
      run_tx(v, 0);
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
